// File: rtl/sram_port_arbiter.sv
// Shares port 0 of an OpenRAM-style single-port sram macro between two requesters.
// Every macro input is registered, so a command accepted at posedge T is sampled
// by the macro at T+1 and accessed at negedge T+1. Read data is captured at T+2
// and returned to the issuing requester as a one-cycle response pulse.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    // Round-robin pointer: 0 means req0 wins the next tie, 1 means req1 wins it.
    logic rrPtr_q, rrPtr_d;

    logic grant0, grant1, handshake;
    logic                  selId;
    logic                  selWe;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic [NUM_WMASKS-1:0] selWmask;

    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;

    // Stage 1 tracks the command the macro is sampling, stage 2 the one whose data is on dout0.
    logic tag1Valid_q, tag1Id_q, tag1We_q;
    logic tag2Valid_q, tag2Id_q, tag2We_q;

    logic                  rsp0Valid_q, rsp0Valid_d;
    logic                  rsp1Valid_q, rsp1Valid_d;
    logic [DATA_WIDTH-1:0] rsp0Rdata_q, rsp0Rdata_d;
    logic [DATA_WIDTH-1:0] rsp1Rdata_q, rsp1Rdata_d;

    // Grant from current valids and pointer; nothing is granted while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0_valid && (!req1_valid || (FIXED_PRIO != 0) || !rrPtr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign handshake  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the winning requester's command fields.
    always_comb begin
        selId    = grant1;
        selWe    = req0_we;
        selAddr  = req0_addr;
        selWdata = req0_wdata;
        selWmask = req0_wmask;
        if (grant1) begin
            selWe    = req1_we;
            selAddr  = req1_addr;
            selWdata = req1_wdata;
            selWmask = req1_wmask;
        end
    end

    // The pointer moves away from whoever was just accepted.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (grant0) begin
            rrPtr_d = 1'b1;
        end else if (grant1) begin
            rrPtr_d = 1'b0;
        end
    end

    // Next macro command: idle deselects, while address and data hold their last values.
    always_comb begin
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = '0;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        if (handshake) begin
            csb0_d   = 1'b0;
            web0_d   = ~selWe;
            wmask0_d = selWe ? selWmask : '0;
            addr0_d  = selAddr;
            din0_d   = selWdata;
        end
    end

    // Response pulse for the tag leaving stage 2; read data is held until that requester's next response.
    always_comb begin
        rsp0Valid_d = tag2Valid_q && !tag2Id_q;
        rsp1Valid_d = tag2Valid_q &&  tag2Id_q;
        rsp0Rdata_d = rsp0Rdata_q;
        rsp1Rdata_d = rsp1Rdata_q;
        if (rsp0Valid_d) begin
            rsp0Rdata_d = tag2We_q ? '0 : dout0;
        end
        if (rsp1Valid_d) begin
            rsp1Rdata_d = tag2We_q ? '0 : dout0;
        end
    end

    // Arbiter pointer and registered macro inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rrPtr_q  <= 1'b0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
        end else begin
            rrPtr_q  <= rrPtr_d;
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
        end
    end

    // Tag pipeline and response registers; reset drops anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag1Valid_q <= 1'b0;
            tag1Id_q    <= 1'b0;
            tag1We_q    <= 1'b0;
            tag2Valid_q <= 1'b0;
            tag2Id_q    <= 1'b0;
            tag2We_q    <= 1'b0;
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            rsp0Rdata_q <= '0;
            rsp1Rdata_q <= '0;
        end else begin
            tag1Valid_q <= handshake;
            tag1Id_q    <= selId;
            tag1We_q    <= selWe;
            tag2Valid_q <= tag1Valid_q;
            tag2Id_q    <= tag1Id_q;
            tag2We_q    <= tag1We_q;
            rsp0Valid_q <= rsp0Valid_d;
            rsp1Valid_q <= rsp1Valid_d;
            rsp0Rdata_q <= rsp0Rdata_d;
            rsp1Rdata_q <= rsp1Rdata_d;
        end
    end

    assign csb0       = csb0_q;
    assign web0       = web0_q;
    assign wmask0     = wmask0_q;
    assign addr0      = addr0_q;
    assign din0       = din0_q;
    assign rsp0_valid = rsp0Valid_q;
    assign rsp1_valid = rsp1Valid_q;
    assign rsp0_rdata = rsp0Rdata_q;
    assign rsp1_rdata = rsp1Rdata_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the OpenRAM-style `sram` macro between two requesters: req0 (data/load-store) and req1 (DMA/debug).
- Registers every macro input at the controller's clock edge, so each command meets the macro's posedge input capture and negedge array access.
- Arbitrates round-robin or fixed-priority, pipelines up to one command per cycle, and routes read data back to the requester that issued the command.

Parameters:
- ADDR_WIDTH, 13, word address width; matches the macro's addr0.
- DATA_WIDTH, 32, data width; must equal 8*NUM_WMASKS.
- NUM_WMASKS, 4, byte-lane write-enable count.
- FIXED_PRIO, 0, 0 = round-robin; 1 = req0 always wins.

Ports:
- clock  in  1  single clock; also drives the macro's clk0.
- reset_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  command valid; N is 0 or 1 (all req/rsp ports are duplicated per N).
- reqN_ready  out  1  command accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_wmask  in  NUM_WMASKS  byte enables; ignored for reads.
- rspN_valid  out  1  one-cycle response pulse for requester N.
- rspN_rdata  out  DATA_WIDTH  read data; 0 for write acknowledgements.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- wmask0  out  NUM_WMASKS  macro byte mask.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
  - reqN_ready=0, round-robin pointer = req0, pipeline tags cleared.
- Reset mid-operation: any in-flight command is dropped and no response is ever issued for it. Requesters must reissue.
- Arbitration is combinational from the current valids and the pointer:
  - Only one valid: that requester is granted.
  - Both valid, FIXED_PRIO=1: req0 is granted.
  - Both valid, FIXED_PRIO=0: the requester not granted last is granted.
  - The pointer updates only on an accepted handshake.
- reqN_ready = grant_N. The arbiter never stalls, so a request is accepted in the same cycle it is granted. A valid that is not granted must hold its request stable.
- Handshake at posedge T:
  - Registered outputs: csb0=0, web0=~we, addr0=addr, din0=wdata.
  - wmask0 = wmask for writes; wmask0 = 0 for reads.
- No handshake at posedge T: csb0=1, web0=1, wmask0=0. addr0 and din0 hold their previous values.
- Response timing:
  - Macro samples the command at posedge T+1 and accesses the array at negedge T+1.
  - Controller captures dout0 at posedge T+2.
  - rspN_valid is high for the cycle following posedge T+2 (latency 2 cycles handshake-to-response).
  - rspN_rdata holds its value until the next response to the same requester.
- A 2-stage tag pipeline (valid, requester id, is_write) carries each command to its response. Writes give rspN_valid=1 with rspN_rdata=0.
- Throughput is one command per cycle. Back-to-back commands to either requester are allowed, and responses return in issue order.
- Write at T followed by a read of the same address at T+1 returns the new data. The write hits the array at negedge T+1, the read at negedge T+2; no forwarding logic.
- A write with wmask=0 still acknowledges and leaves memory unchanged.
- Address wrap: the address is used modulo 2^ADDR_WIDTH; there is no range check.
- Only one rspN_valid is asserted per cycle.

Test Plan:
- Single read: memory preloaded with word 0x10 = 0xDEADBEEF; req0 read addr 0x10 accepted at T -> csb0=0, web0=1 after T; rsp0_valid=1 after T+2 with rdata 0xDEADBEEF; rsp1_valid stays 0.
- Byte-masked write: req1 write addr 0x1FFF, wdata 0x11223344, wmask 0b0101, over old 0xAABBCCDD; then read -> rsp1 ack with rdata 0, then read returns 0xAA22CC44.
- Contention, FIXED_PRIO=0: both valid for 4 cycles -> grants alternate req0, req1, req0, req1; responses arrive in the same order, 2 cycles later.
- Contention, FIXED_PRIO=1: both valid for 3 cycles -> req0 granted every cycle, req1_ready=0 throughout; req1 is granted in the first cycle req0_valid=0.
- Write-then-read hazard: req0 write addr 5 = 0xCAFEF00D at T, req1 read addr 5 at T+1 -> rsp1_rdata=0xCAFEF00D.
- Reset mid-flight: reset_n pulled low 1 cycle after a read handshake -> all outputs immediately at reset values; no rsp pulse after reset release; the next request completes normally with latency 2.
